// File: rtl/coeff_bank_loader.sv
// Coefficient bank loader: queues host coefficient writes, drains them into the signal path
// while the datapath is idle, and applies bank-select commits. Option: COEFF_LOADER_CHECKSUM_EN.
module coeff_bank_loader #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [1:0]                 wr_axis,
  input  logic [1:0]                 wr_bank,
  input  logic [3:0]                 wr_index,
  input  logic [15:0]                wr_value,
  input  logic                       commit_valid,
  output logic                       commit_ready,
  input  logic [1:0]                 commit_axis,
  input  logic [1:0]                 commit_bank,
  input  logic                       available,
  output logic                       update_en,
  output logic [1:0]                 update_axis,
  output logic [1:0]                 update_bank,
  output logic [3:0]                 update_index,
  output logic [15:0]                update_value,
  output logic [1:0]                 x_bank,
  output logic [1:0]                 y_bank,
  output logic [1:0]                 z_bank,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err,
`ifdef COEFF_LOADER_CHECKSUM_EN
  output logic [15:0]                checksum,
`endif
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_t;

  state_t        state_q, state_d;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, wr_fire, push, pop, commit_fire;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign wr_ready     = !full;
  assign wr_fire      = wr_valid && !full;
  assign push         = wr_fire && (wr_axis != 2'd0);
  assign pop          = (state_q == StDrain) && available && !empty;
  // Commit waits for an empty queue and a quiet update port so queued taps land first.
  assign commit_ready = (state_q == StCommit) && available && !update_en && empty;
  assign commit_fire  = commit_valid && commit_ready;
  assign fifo_level   = level_q;
  assign busy         = !empty || (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StDrain;
        else if (commit_valid) state_d = StCommit;
      end
      StDrain: begin
        if (empty) state_d = StIdle;
      end
      StCommit: begin
        if (commit_fire || !commit_valid || !empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= {wr_axis, wr_bank, wr_index, wr_value};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      update_en    <= 1'b0;
      update_axis  <= '0;
      update_bank  <= '0;
      update_index <= '0;
      update_value <= '0;
      err          <= 1'b0;
      x_bank       <= '0;
      y_bank       <= '0;
      z_bank       <= '0;
    end else begin
      update_en <= pop;
      if (pop) {update_axis, update_bank, update_index, update_value} <= mem[rd_ptr_q];
      err <= (wr_fire && (wr_axis == 2'd0)) || (commit_fire && (commit_axis == 2'd0));
      if (commit_fire) begin
        case (commit_axis)
          2'd1:    x_bank <= commit_bank;
          2'd2:    y_bank <= commit_bank;
          2'd3:    z_bank <= commit_bank;
          default: ;
        endcase
      end
    end
  end

`ifdef COEFF_LOADER_CHECKSUM_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (commit_fire) begin
      checksum <= '0;
    end else if (update_en) begin
      checksum <= checksum ^ update_value;
    end
  end
`endif

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Self-checking bench for coeff_bank_loader: vector table plus scoreboard of expected updates.
// Checksum checks are included when COEFF_LOADER_CHECKSUM_EN is defined.
module tb_coeff_bank_loader;
  localparam int unsigned DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_axis, wr_bank;
  logic [3:0]  wr_index;
  logic [15:0] wr_value;
  logic        commit_valid, commit_ready;
  logic [1:0]  commit_axis, commit_bank;
  logic        available;
  logic        update_en;
  logic [1:0]  update_axis, update_bank;
  logic [3:0]  update_index;
  logic [15:0] update_value;
  logic [1:0]  x_bank, y_bank, z_bank;
  logic [2:0]  fifo_level;
  logic        err, busy;
`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  coeff_bank_loader #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_axis(wr_axis), .wr_bank(wr_bank),
    .wr_index(wr_index), .wr_value(wr_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_axis(commit_axis), .commit_bank(commit_bank), .available(available),
    .update_en(update_en), .update_axis(update_axis), .update_bank(update_bank),
    .update_index(update_index), .update_value(update_value),
    .x_bank(x_bank), .y_bank(y_bank), .z_bank(z_bank), .fifo_level(fifo_level), .err(err),
`ifdef COEFF_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]  axis;
    logic [1:0]  bank;
    logic [3:0]  index;
    logic [15:0] value;
  } upd_t;

  typedef struct {
    logic [1:0]  axis;
    logic [1:0]  bank;
    logic [3:0]  index;
    logic [15:0] value;
    int          exp_upd;
    int          exp_err;
  } vec_t;

  upd_t sb[$];
  int   total = 0, bad = 0;
  int   cycle = 0, upd_cnt = 0, err_cnt = 0, commit_cnt = 0;
  int   first_upd = -1, last_upd = 0;
  logic [1:0] exp_x = 2'd0, exp_y = 2'd0, exp_z = 2'd0;
  logic commit_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Handshakes are sampled at the falling edge, outputs 1 time unit after the rising edge.
  task automatic tick();
    upd_t e;
    @(negedge sys_clk);
    if (wr_valid && wr_ready && wr_axis != 2'd0)
      sb.push_back({wr_axis, wr_bank, wr_index, wr_value});
    if (commit_valid && commit_ready) begin
      commit_cnt++;
      commit_seen = 1'b1;
      check("commit_queue_drained", sb.size(), 0);
      check("commit_fifo_empty", fifo_level, 0);
      case (commit_axis)
        2'd1:    exp_x = commit_bank;
        2'd2:    exp_y = commit_bank;
        2'd3:    exp_z = commit_bank;
        default: ;
      endcase
    end
    @(posedge sys_clk);
    #1;
    cycle++;
    if (update_en) begin
      upd_cnt++;
      if (first_upd < 0) first_upd = cycle;
      last_upd = cycle;
      check("update_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("update_fields", {update_axis, update_bank, update_index, update_value}, e);
      end
    end
    if (err) err_cnt++;
  endtask

  task automatic drive_wr(input logic [1:0] a, input logic [1:0] b, input logic [3:0] i,
                          input logic [15:0] v);
    wr_valid = 1'b1;
    wr_axis  = a;
    wr_bank  = b;
    wr_index = i;
    wr_value = v;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || update_en) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic wait_commit(input int budget);
    int n = 0;
    while (!commit_seen && n < budget) begin
      tick();
      n++;
    end
    check("commit_within_budget", commit_seen, 1);
  endtask

  task automatic check_banks();
    check("banks", {x_bank, y_bank, z_bank}, {exp_x, exp_y, exp_z});
  endtask

  task automatic check_reset_outputs();
    check("rst_update_en", update_en, 0);
    check("rst_err", err, 0);
    check("rst_commit_ready", commit_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_update_fields", {update_axis, update_bank, update_index, update_value}, 0);
    check("rst_banks", {x_bank, y_bank, z_bank}, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int u0, e0, c0;

    vecs[0] = '{2'd1, 2'd2, 4'd5,  16'h1234, 1, 0};
    vecs[1] = '{2'd2, 2'd1, 4'd15, 16'hFFFF, 1, 0};
    vecs[2] = '{2'd3, 2'd3, 4'd0,  16'h0001, 1, 0};
    vecs[3] = '{2'd0, 2'd1, 4'd3,  16'hBEEF, 0, 1};
    vecs[4] = '{2'd3, 2'd0, 4'd9,  16'hA5A5, 1, 0};
    vecs[5] = '{2'd2, 2'd2, 4'd7,  16'h8000, 1, 0};

    reset = 1'b1;
    wr_valid = 1'b0; wr_axis = '0; wr_bank = '0; wr_index = '0; wr_value = '0;
    commit_valid = 1'b0; commit_axis = '0; commit_bank = '0;
    available = 1'b1;
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // Table: one write each, drained with available high.
    for (int i = 0; i < 6; i++) begin
      u0 = upd_cnt;
      e0 = err_cnt;
      drive_wr(vecs[i].axis, vecs[i].bank, vecs[i].index, vecs[i].value);
      tick();
      wr_valid = 1'b0;
      wait_idle(20);
      check("vec_updates", upd_cnt - u0, vecs[i].exp_upd);
      check("vec_err", err_cnt - e0, vecs[i].exp_err);
    end
    check("update_hold", {update_axis, update_bank, update_index, update_value},
          {vecs[5].axis, vecs[5].bank, vecs[5].index, vecs[5].value});

    // Write-to-update latency.
    drive_wr(2'd1, 2'd2, 4'd5, 16'h1234);
    tick();
    wr_valid = 1'b0;
    check("lat_e0_update_en", update_en, 0);
    check("lat_e0_level", fifo_level, 1);
    tick();
    check("lat_e1_update_en", update_en, 0);
    tick();
    check("lat_e2_update_en", update_en, 1);
    tick();
    tick();
    check("lat_level_back", fifo_level, 0);
    check("lat_busy_back", busy, 0);

    // Fill while unavailable, then drain on consecutive cycles.
    available = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(2'(i % 3 + 1), 2'(i), 4'(i + 8), 16'hC000 + 16'(i));
      tick();
    end
    drive_wr(2'd1, 2'd1, 4'd1, 16'hDEAD);
    #1;
    check("full_wr_ready", wr_ready, 0);
    check("full_level", fifo_level, 4);
    tick();
    wr_valid = 1'b0;
    check("full_level_hold", fifo_level, 4);
    u0 = upd_cnt;
    first_upd = -1;
    available = 1'b1;
    wait_idle(20);
    check("full_drain_count", upd_cnt - u0, 4);
    check("full_drain_consecutive", last_upd - first_upd, 3);

    // Push and pop on the same edge keeps the level.
    available = 1'b0;
    drive_wr(2'd2, 2'd3, 4'd4, 16'h5A5A);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    available = 1'b1;
    drive_wr(2'd3, 2'd1, 4'd6, 16'h6B6B);
    tick();
    wr_valid = 1'b0;
    check("push_pop_level", fifo_level, 1);
    wait_idle(20);

    // Commit issued alongside the last queued write must follow all updates.
    available = 1'b0;
    u0 = upd_cnt;
    c0 = commit_cnt;
    commit_seen = 1'b0;
    drive_wr(2'd1, 2'd0, 4'd1, 16'h1111);
    tick();
    drive_wr(2'd2, 2'd1, 4'd2, 16'h2222);
    tick();
    drive_wr(2'd3, 2'd2, 4'd3, 16'h3333);
    commit_valid = 1'b1;
    commit_axis  = 2'd2;
    commit_bank  = 2'd3;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("commit_blocked_unavailable", commit_cnt - c0, 0);
    available = 1'b1;
    wait_commit(30);
    commit_valid = 1'b0;
    check("commit_after_updates", upd_cnt - u0, 3);
    check("commit_y_bank", y_bank, 3);
    check_banks();
    wait_idle(20);

    // Axis-0 write and commit: errors only.
    u0 = upd_cnt;
    e0 = err_cnt;
    drive_wr(2'd0, 2'd2, 4'd8, 16'h7777);
    tick();
    wr_valid = 1'b0;
    commit_seen  = 1'b0;
    commit_valid = 1'b1;
    commit_axis  = 2'd0;
    commit_bank  = 2'd1;
    wait_commit(20);
    commit_valid = 1'b0;
    tick();
    tick();
    check("axis0_err_pulses", err_cnt - e0, 2);
    check("axis0_no_update", upd_cnt - u0, 0);
    check_banks();

    // Reset in the middle of a drain.
    available = 1'b0;
    drive_wr(2'd1, 2'd1, 4'd2, 16'h4444);
    tick();
    drive_wr(2'd3, 2'd2, 4'd3, 16'h5555);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_level", fifo_level, 2);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    sb.delete();
    exp_x = 2'd0; exp_y = 2'd0; exp_z = 2'd0;
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b0;
    available = 1'b1;
    u0 = upd_cnt;
    repeat (6) tick();
    check("post_reset_no_update", upd_cnt - u0, 0);
    check("post_reset_level", fifo_level, 0);

`ifdef COEFF_LOADER_CHECKSUM_EN
    check("csum_after_reset", checksum, 0);
    drive_wr(2'd1, 2'd0, 4'd0, 16'h00FF);
    tick();
    drive_wr(2'd2, 2'd0, 4'd1, 16'h0F0F);
    tick();
    wr_valid = 1'b0;
    wait_idle(20);
    check("csum_xor", checksum, 16'h0FF0);
    commit_seen  = 1'b0;
    commit_valid = 1'b1;
    commit_axis  = 2'd1;
    commit_bank  = 2'd1;
    wait_commit(20);
    commit_valid = 1'b0;
    check("csum_cleared_by_commit", checksum, 0);
    check_banks();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/coeff_bank_loader.md
COEFF_BANK_LOADER -- requirements
Module: coeff_bank_loader

Interface
REQ-001 Parameter DEPTH, default 4, gives the write FIFO depth in entries; the value SHALL be a power of 2 and at least 2.
REQ-002 sys_clk  in  1  is the single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  is an asynchronous, active-high reset.
REQ-004 wr_valid/wr_ready  in/out  1/1  form the host coefficient-write handshake; a transfer SHALL occur when both are high on a clock edge.
REQ-005 wr_axis, wr_bank, wr_index, wr_value  in  2/2/4/16  carry the axis (1=x, 2=y, 3=z), bank, tap and coefficient value of a host write.
REQ-006 commit_valid/commit_ready  in/out  1/1  form the bank-select commit handshake; commit_axis  in  2 and commit_bank  in  2 carry the target.
REQ-007 available  in  1  is high while the filter datapath is idle and coefficients may change.
REQ-008 update_en, update_axis, update_bank, update_index, update_value  out  1/2/2/4/16  form the coefficient-write port into the signal path.
REQ-009 x_bank, y_bank, z_bank  out  2 each  are the active bank selects.
REQ-010 fifo_level  out  $clog2(DEPTH)+1  is the number of FIFO entries occupied.
REQ-011 err  out  1  is a single-cycle error pulse.
REQ-012 busy  out  1  is high whenever the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-013 wr_ready SHALL equal !full; there is no pass-through when full, even if a pop happens in the same cycle.
REQ-014 A write accepted with wr_axis=0 SHALL NOT be stored, and err SHALL pulse on the next cycle.
REQ-015 The FSM SHALL have exactly the states IDLE, DRAIN and COMMIT.
REQ-016 IDLE SHALL go to DRAIN when the FIFO is non-empty; otherwise it SHALL go to COMMIT when commit_valid is high.
REQ-017 In DRAIN, one entry SHALL be popped in each cycle where available=1 and the FIFO is non-empty.
REQ-018 DRAIN SHALL return to IDLE in the cycle after the FIFO becomes empty.
REQ-019 For each pop, update_en SHALL be high for exactly one cycle on the next cycle, with the popped fields registered onto update_*.
REQ-020 No pop SHALL occur while available=0; one update_en already registered from the previous cycle may still complete.
REQ-021 update_* SHALL hold their last values while update_en=0.
REQ-022 In COMMIT, commit_ready SHALL pulse for one cycle, and only if available=1 and update_en=0.
REQ-023 On accept, the matching bank register SHALL load commit_bank on the next cycle, and the FSM SHALL return to IDLE.
REQ-024 commit_axis=0 SHALL be accepted with no bank change, and err SHALL pulse.
REQ-025 Commit SHALL never be accepted while the FIFO is non-empty: all writes queued before a commit reach the datapath first.
REQ-026 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-027 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-028 A write to the currently active bank SHALL be permitted; it takes effect only while available=1.

Reset
REQ-029 During and after reset, the outputs SHALL be: the FIFO empty, fifo_level=0, state IDLE, and update_en, err, commit_ready, busy all 0.
REQ-030 During and after reset, update_* SHALL be 0 and x_bank, y_bank, z_bank SHALL be 0.
REQ-031 Reset asserted mid-DRAIN SHALL discard all queued entries, and no update_en SHALL follow the reset release.

Configuration
REQ-032 Macro COEFF_LOADER_CHECKSUM_EN controls a checksum feature.
REQ-033 When COEFF_LOADER_CHECKSUM_EN is defined, output checksum [15:0] SHALL XOR-accumulate update_value on every update_en cycle.
REQ-034 When COEFF_LOADER_CHECKSUM_EN is defined, checksum SHALL clear to 0 on reset and in the cycle after each accepted commit.
REQ-035 When COEFF_LOADER_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent.

Verification
REQ-036 Write (1,2,5,0x1234) with available=1 -> update_en high 2 cycles after the write edge, with axis 1, bank 2, index 5, value 0x1234; fifo_level returns to 0.
REQ-037 With available=0, push 4 writes, then attempt a 5th -> wr_ready=0 and fifo_level=4; raise available -> 4 update_en pulses on consecutive cycles in FIFO order.
REQ-038 Queue 3 writes, then commit (2,3) in the same cycle as the last write -> all 3 update_en pulses occur before commit_ready, and y_bank=3 in the cycle after commit_ready.
REQ-039 Send a write with axis 0 and a commit with axis 0 -> err pulses once for each, no update_en occurs, and the banks are unchanged.
REQ-040 Assert reset while 2 entries are queued in DRAIN -> all outputs are 0 immediately and no update_en follows release; with COEFF_LOADER_CHECKSUM_EN, values 0x00FF then 0x0F0F -> checksum=0x0FF0.
